fetch_unit: RTL and testbench

Instruction fetch stage of the RAPID core: holds the program counter, presents fetch addresses to `i_cache`, and captures returned instruction words with their PC into a small buffer. Instructions go to decode over a valid/ready handshake. Sits directly upstream of `i_cache` and of decode; redirects from execute restart the fetch stream.

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; PC register, i_cache address/return handling, {pc, instr} buffer to decode.
// Ports:
//   i_clk, i_reset            clock and asynchronous active-high reset
//   o_icache_address          current PC presented to i_cache
//   i_icache_data/done        registered i_cache return
//   i_redirect/_pc            one-cycle fetch restart request and target
//   o_dec_valid/instr/pc      buffer head towards decode
//   i_dec_ready               decode accepts the head
// Build option: FETCH_QUEUE_EN selects a 2-entry buffer instead of a single output register.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic [XLEN-1:0] o_icache_address,
    input  logic [XLEN-1:0] i_icache_data,
    input  logic            i_icache_done,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_dec_valid,
    output logic [XLEN-1:0] o_dec_instr,
    output logic [XLEN-1:0] o_dec_pc,
    input  logic            i_dec_ready
);
`ifdef FETCH_QUEUE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);
    // a single-entry buffer still needs a 1-bit pointer; it simply never leaves 0
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 2 ** PW;

    typedef enum logic [1:0] {ISSUE, WAIT, FULL} state_t;

    state_t state, state_nx;
    logic [XLEN-1:0] pc, redirect_pc;
    logic [XLEN-1:0] mem_pc [SLOTS];
    logic [XLEN-1:0] mem_instr [SLOTS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic push, pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign redirect_pc = i_redirect_pc & ~XLEN'(3);
    assign o_icache_address = pc;
    assign o_dec_valid = count != '0;
    assign o_dec_instr = mem_instr[rd_ptr];
    assign o_dec_pc = mem_pc[rd_ptr];
    // a done outside WAIT belongs to an older address and is ignored
    assign push = state == WAIT && i_icache_done && !i_redirect;
    assign pop = o_dec_valid && i_dec_ready;
    assign count_nx = count + CW'(push) - CW'(pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ISSUE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = i_redirect ? ISSUE :
                   state == ISSUE ? WAIT :
                   state == WAIT ? (i_icache_done ? (count_nx == CW'(DEPTH) ? FULL : ISSUE) : WAIT) :
                   pop ? ISSUE : FULL;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc <= RESET_VECTOR;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem_pc[i] <= '0;
                mem_instr[i] <= '0;
            end
        end else if (i_redirect) begin
            pc <= redirect_pc;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nx;
            if (push) begin
                mem_pc[wr_ptr] <= pc;
                mem_instr[wr_ptr] <= i_icache_data;
                wr_ptr <= bump(wr_ptr);
                pc <= pc + XLEN'(4);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (RESET_VECTOR = 0x100).
module tb_fetch_unit;
`ifdef FETCH_QUEUE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        clk, reset, done, redirect, dec_valid, dec_ready;
    logic [31:0] addr, data, redirect_pc, dec_instr, dec_pc;
    int checks = 0;
    int errors = 0;

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h100)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .o_icache_address(addr),
        .i_icache_data(data),
        .i_icache_done(done),
        .i_redirect(redirect),
        .i_redirect_pc(redirect_pc),
        .o_dec_valid(dec_valid),
        .o_dec_instr(dec_instr),
        .o_dec_pc(dec_pc),
        .i_dec_ready(dec_ready)
    );

    assign data = addr ^ KEY;

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[9];
    int nv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic collect(input string name, input logic [31:0] exp_pc);
        for (int n = 0; n < 40; n++) begin
            #1;
            if (dec_valid && dec_ready) begin
                chk({name, " pc"}, dec_pc, exp_pc);
                chk({name, " instr"}, dec_instr, exp_pc ^ KEY);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for pc %h", name, exp_pc);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect = 1;
        redirect_pc = target;
        @(negedge clk);
        redirect = 0;
    endtask

    initial begin
        if (DEPTH == 2) begin
            nv = 7;
            tbl[0] = '{1, 0, 0, 32'h100};
            tbl[1] = '{1, 0, 0, 32'h100};
            tbl[2] = '{1, 1, 32'h100, 32'h104};
            tbl[3] = '{1, 0, 0, 32'h104};
            tbl[4] = '{1, 1, 32'h104, 32'h108};
            tbl[5] = '{1, 0, 0, 32'h108};
            tbl[6] = '{1, 1, 32'h108, 32'h10C};
        end else begin
            nv = 9;
            tbl[0] = '{1, 0, 0, 32'h100};
            tbl[1] = '{1, 0, 0, 32'h100};
            tbl[2] = '{1, 1, 32'h100, 32'h104};
            tbl[3] = '{1, 0, 0, 32'h104};
            tbl[4] = '{1, 0, 0, 32'h104};
            tbl[5] = '{1, 1, 32'h104, 32'h108};
            tbl[6] = '{1, 0, 0, 32'h108};
            tbl[7] = '{1, 0, 0, 32'h108};
            tbl[8] = '{1, 1, 32'h108, 32'h10C};
        end
        reset = 1;
        done = 1;
        redirect = 0;
        redirect_pc = 0;
        dec_ready = 1;
        repeat (2) @(negedge clk);
        chk("reset valid", {31'b0, dec_valid}, 0);
        chk("reset addr", addr, 32'h100);
        chk("reset instr", dec_instr, 0);
        chk("reset pc", dec_pc, 0);
        reset = 0;
        for (int k = 0; k < nv; k++) begin
            dec_ready = tbl[k].ready;
            #1;
            chk($sformatf("stream%0d valid", k), {31'b0, dec_valid}, {31'b0, tbl[k].exp_valid});
            chk($sformatf("stream%0d addr", k), addr, tbl[k].exp_addr);
            if (tbl[k].exp_valid) begin
                chk($sformatf("stream%0d pc", k), dec_pc, tbl[k].exp_pc);
                chk($sformatf("stream%0d instr", k), dec_instr, tbl[k].exp_pc ^ KEY);
            end
            @(negedge clk);
        end
        dec_ready = 0;
        do_redirect(32'h300);
        chk("redir valid", {31'b0, dec_valid}, 0);
        chk("redir addr", addr, 32'h300);
        repeat (5) @(negedge clk);
        chk("stall5 addr", addr, 32'h300 + 32'(4 * DEPTH));
        chk("stall5 valid", {31'b0, dec_valid}, 1);
        repeat (5) @(negedge clk);
        chk("stall10 addr", addr, 32'h300 + 32'(4 * DEPTH));
        chk("stall10 pc", dec_pc, 32'h300);
        chk("stall10 instr", dec_instr, 32'h300 ^ KEY);
        dec_ready = 1;
        collect("drain0", 32'h300);
        collect("drain1", 32'h304);
        collect("drain2", 32'h308);
        collect("drain3", 32'h30C);
        done = 0;
        do_redirect(32'h500);
        chk("r500 addr", addr, 32'h500);
        repeat (2) @(negedge clk);
        chk("wait addr", addr, 32'h500);
        chk("wait valid", {31'b0, dec_valid}, 0);
        done = 1;
        do_redirect(32'h2003);
        done = 0;
        chk("drop valid", {31'b0, dec_valid}, 0);
        chk("drop addr", addr, 32'h2000);
        @(negedge clk);
        chk("drop valid2", {31'b0, dec_valid}, 0);
        done = 1;
        collect("after drop", 32'h2000);
        do_redirect(32'hFFFF_FFFC);
        collect("wrap0", 32'hFFFF_FFFC);
        collect("wrap1", 32'h0000_0000);
        dec_ready = 0;
        do_redirect(32'h700);
        repeat (8) @(negedge clk);
        chk("pre-reset valid", {31'b0, dec_valid}, 1);
        #1 reset = 1;
        #1;
        chk("async valid", {31'b0, dec_valid}, 0);
        chk("async addr", addr, 32'h100);
        chk("async instr", dec_instr, 0);
        chk("async pc", dec_pc, 0);
        @(negedge clk);
        reset = 0;
        dec_ready = 1;
        collect("restart0", 32'h100);
        collect("restart1", 32'h104);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
